seven_segment_pager: RTL and testbench

//  Registered, parametrised hex display driver for DIGITS seven-segment digits showing a DATA_W-bit word.

---
 rtl/seven_segment_pager_pkg.sv | 62 ++++++
 rtl/hex7_decode.sv | 11 +
 rtl/seven_segment_pager.sv | 185 ++++++++++++++++++
 tb/tb_seven_segment_pager.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_pager_pkg.sv
// Shared definitions for the seven-segment pager: mode and FSM encodings,
// the blank pattern, the nibble->segment table and width helpers.
package seven_segment_pager_pkg;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'd0,
        MODE_AUTO   = 2'd1,
        MODE_SELECT = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_e;

    // Active-low segments, bit0 = a .. bit6 = g; all ones turns the digit off.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Nibble to active-low segment pattern.
    function automatic logic [6:0] nibble_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // The reserved mode encoding behaves exactly like MANUAL.
    function automatic mode_e mode_decode(input logic [1:0] raw);
        mode_e m;
        case (raw)
            2'd1:    m = MODE_AUTO;
            2'd2:    m = MODE_SELECT;
            default: m = MODE_MANUAL;
        endcase
        return m;
    endfunction

    // Width of the page index; at least one bit even with a single page.
    function automatic int page_width(input int data_w, input int digits);
        int pages;
        pages = data_w / (4 * digits);
        return (pages > 1) ? $clog2(pages) : 1;
    endfunction

endpackage

// File: rtl/hex7_decode.sv
// Combinational nibble to seven-segment decoder (active-low outputs).
module hex7_decode
    import seven_segment_pager_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = nibble_to_seg(i_nibble);

endmodule

// File: rtl/seven_segment_pager.sv
// Paged hex display driver: latches a word from a valid/ready write port and
// shows one DIGITS-nibble page of it at a time on registered, active-low
// segment outputs. Pages advance manually, automatically on a dwell timer,
// or are selected directly.
// Optional feature: define SEVEN_SEG_BLINK_EN to add the blink phase counter
// that blanks the display on alternate BLINK_CYCLES periods while i_blink=1.
module seven_segment_pager
    import seven_segment_pager_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int DIGITS       = 4,
    parameter int DWELL_CYCLES = 50000000,
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic [DATA_W-1:0]                     i_data,
    input  logic                                  i_valid,
    output logic                                  o_ready,
    input  logic                                  i_hold,
    input  logic [1:0]                            i_mode,
    input  logic                                  i_next,
    input  logic [page_width(DATA_W, DIGITS)-1:0] i_page_sel,
    input  logic                                  i_blink,
    output logic [page_width(DATA_W, DIGITS)-1:0] o_page,
    output logic [7*DIGITS-1:0]                   o_hex
);

    localparam int PAGE_BITS = 4 * DIGITS;
    localparam int PAGES     = DATA_W / PAGE_BITS;
    localparam int PAGE_W    = page_width(DATA_W, DIGITS);
    localparam int DWELL_W   = $clog2(DWELL_CYCLES);

    localparam logic [PAGE_W-1:0]  LAST_PAGE  = PAGE_W'(PAGES - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

    state_e                state_q, state_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic [PAGE_W-1:0]     page_q, page_d;
    logic [DWELL_W-1:0]    dwell_q, dwell_d;
    mode_e                 mode_q;
    logic                  next_q;
    logic [7*DIGITS-1:0]   hex_q, hex_d;
    logic [PAGE_W-1:0]     page_out_q;

    mode_e                 mode_cur;
    logic                  accept;
    logic                  next_rise;
    logic [PAGE_W-1:0]     sel_page;
    logic [PAGE_BITS-1:0]  page_word;
    logic [7*DIGITS-1:0]   seg_all;
    logic                  blink_blank;

    function automatic logic [PAGE_W-1:0] page_inc(input logic [PAGE_W-1:0] p);
        return (p == LAST_PAGE) ? '0 : p + PAGE_W'(1);
    endfunction

    assign o_ready   = ~i_hold;
    assign accept    = i_valid & ~i_hold;
    assign mode_cur  = mode_decode(i_mode);
    assign next_rise = i_next & ~next_q;
    assign sel_page  = (i_page_sel > LAST_PAGE) ? LAST_PAGE : i_page_sel;
    assign page_word = data_q[page_q*PAGE_BITS +: PAGE_BITS];

    // Digit 0 shows the most significant nibble of the current page.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            hex7_decode u_dec (
                .i_nibble (page_word[4*(DIGITS-1-gi) +: 4]),
                .o_seg    (seg_all[7*gi +: 7])
            );
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_BLANK;
        else          state_q <= state_d;
    end

    // FSM next state: the first accepted write turns the display on for good.
    always_comb begin
        state_d = state_q;
        if (accept) state_d = ST_SHOW;
    end

    // FSM output: blank until something was written or while blinked off.
    always_comb begin
        hex_d = seg_all;
        if (state_q == ST_BLANK || blink_blank) hex_d = {DIGITS{SEG_BLANK}};
    end

    // Write capture.
    always_comb begin
        data_d = data_q;
        if (accept) data_d = i_data;
    end

    // Page and dwell timer; everything holds still while i_hold is high.
    always_comb begin
        page_d  = page_q;
        dwell_d = dwell_q;
        if (!i_hold) begin
            if (accept || mode_cur != mode_q) begin
                dwell_d = '0;
            end else begin
                case (mode_cur)
                    MODE_AUTO: begin
                        if (dwell_q == DWELL_LAST) begin
                            dwell_d = '0;
                            page_d  = page_inc(page_q);
                        end else begin
                            dwell_d = dwell_q + DWELL_W'(1);
                        end
                    end
                    MODE_SELECT: begin
                        dwell_d = '0;
                        page_d  = sel_page;
                    end
                    default: begin
                        dwell_d = '0;
                        if (next_rise) page_d = page_inc(page_q);
                    end
                endcase
            end
        end
    end

    // Datapath, counters, edge detector and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q     <= '0;
            page_q     <= '0;
            dwell_q    <= '0;
            mode_q     <= MODE_MANUAL;
            next_q     <= 1'b0;
            hex_q      <= {DIGITS{SEG_BLANK}};
            page_out_q <= '0;
        end else begin
            data_q     <= data_d;
            page_q     <= page_d;
            dwell_q    <= dwell_d;
            next_q     <= i_next;
            hex_q      <= hex_d;
            page_out_q <= page_q;
            // A mode change seen during hold is acted on once hold drops.
            if (!i_hold) mode_q <= mode_cur;
        end
    end

`ifdef SEVEN_SEG_BLINK_EN
    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    logic [BLINK_W-1:0] blink_cnt_q;
    logic               blink_phase_q;

    // Blink phase toggles every BLINK_CYCLES while enabled, restarts when off.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (!i_blink) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
        end else begin
            blink_cnt_q   <= blink_cnt_q + BLINK_W'(1);
        end
    end

    assign blink_blank = i_blink & blink_phase_q;
`else
    localparam int unused_blink_cycles = BLINK_CYCLES;
    logic unused_blink;
    assign unused_blink = i_blink;
    assign blink_blank  = 1'b0;
`endif

    assign o_hex  = hex_q;
    assign o_page = page_out_q;

endmodule

// File: tb/tb_seven_segment_pager.sv
// Self-checking bench for seven_segment_pager: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_seven_segment_pager;

    localparam int DATA_W = 32;
    localparam int DIGITS = 4;
    localparam int PAGES  = DATA_W / (4 * DIGITS);
    localparam int DWELL  = 8;
    localparam int BLINK  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] i_data;
    logic        i_valid, i_hold, i_next, i_blink;
    logic [1:0]  i_mode;
    logic [0:0]  i_page_sel;
    logic        o_ready;
    logic [0:0]  o_page;
    logic [27:0] o_hex;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [27:0] HEX_OFF  = 28'hFFF_FFFF;
    localparam logic [27:0] HEX_BEEF = {7'h0E, 7'h06, 7'h06, 7'h03};
    localparam logic [27:0] HEX_DEAD = {7'h21, 7'h08, 7'h06, 7'h21};
    localparam logic [27:0] HEX_1234 = {7'h19, 7'h30, 7'h24, 7'h79};

    seven_segment_pager #(
        .DATA_W(DATA_W), .DIGITS(DIGITS), .DWELL_CYCLES(DWELL), .BLINK_CYCLES(BLINK)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(i_data), .i_valid(i_valid),
        .o_ready(o_ready), .i_hold(i_hold), .i_mode(i_mode), .i_next(i_next),
        .i_page_sel(i_page_sel), .i_blink(i_blink), .o_page(o_page), .o_hex(o_hex)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Segment pattern lit for each hex digit, written active-high as gfedcba.
    function automatic logic [6:0] seg_on(input int n);
        case (n)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;  10: return 7'h77; 11: return 7'h7C;
            12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    function automatic logic [27:0] render(input logic [31:0] d, input int p);
        logic [27:0] r;
        int nib;
        r = '0;
        for (int k = 0; k < DIGITS; k++) begin
            nib = int'((d >> (4 * DIGITS * p + 4 * (DIGITS - 1 - k))) & 32'hF);
            r[7*k +: 7] = ~seg_on(nib);
        end
        return r;
    endfunction

    // Behavioural model: what the display must show after each clock edge.
    logic        m_shown;
    logic [31:0] m_data;
    int          m_page, m_dwell, m_prev_mode, m_blink_run;
    logic        m_prev_next;
    logic [27:0] exp_hex = HEX_OFF;
    int          exp_page = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_shown = 1'b0; m_data = '0; m_page = 0; m_dwell = 0;
            m_prev_mode = 0; m_blink_run = 0; m_prev_next = 1'b0;
            exp_hex = HEX_OFF; exp_page = 0;
        end else begin
            int  eff_mode;
            logic rise, blanked;
            blanked = 1'b0;
`ifdef SEVEN_SEG_BLINK_EN
            blanked = i_blink && (((m_blink_run / BLINK) % 2) == 1);
            m_blink_run = i_blink ? m_blink_run + 1 : 0;
`endif
            exp_hex  = (m_shown && !blanked) ? render(m_data, m_page) : HEX_OFF;
            exp_page = m_page;
            eff_mode = (i_mode == 2'd3) ? 0 : int'(i_mode);
            rise = i_next && !m_prev_next;
            m_prev_next = i_next;
            if (!i_hold) begin
                if (i_valid) begin
                    m_shown = 1'b1; m_data = i_data; m_dwell = 0;
                end else if (eff_mode != m_prev_mode) begin
                    m_dwell = 0;
                end else if (eff_mode == 1) begin
                    if (m_dwell == DWELL - 1) begin
                        m_dwell = 0; m_page = (m_page + 1) % PAGES;
                    end else begin
                        m_dwell++;
                    end
                end else if (eff_mode == 2) begin
                    m_page = (int'(i_page_sel) > PAGES - 1) ? PAGES - 1 : int'(i_page_sel);
                end else if (rise) begin
                    m_page = (m_page + 1) % PAGES;
                end
                m_prev_mode = eff_mode;
            end
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("model_hex", 64'(o_hex), 64'(exp_hex));
        check("model_page", 64'(o_page), 64'(exp_page));
        check("model_ready", 64'(o_ready), 64'(!i_hold));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic write(input logic [31:0] d);
        i_data = d; i_valid = 1'b1;
        step(1);
        i_valid = 1'b0;
    endtask

    initial begin
        logic [0:0] p;
        int cnt, blanks;
        rst_n = 1'b0; i_data = '0; i_valid = 0; i_hold = 0; i_next = 0;
        i_blink = 0; i_mode = 2'd0; i_page_sel = '0;
        step(3);
        rst_n = 1'b1;
        step(2);
        check("reset_hex", 64'(o_hex), 64'(HEX_OFF));
        check("reset_page", 64'(o_page), 64'd0);
        check("reset_ready", 64'(o_ready), 64'd1);

        // Manual paging.
        write(32'hDEAD_BEEF);
        step(1);
        check("write_beef", 64'(o_hex), 64'(HEX_BEEF));
        i_next = 1; step(1); i_next = 0; step(1);
        check("next_page1", 64'(o_page), 64'd1);
        check("next_dead", 64'(o_hex), 64'(HEX_DEAD));
        i_next = 1; step(1); i_next = 0; step(1);
        check("next_wrap", 64'(o_page), 64'd0);
        check("next_wrap_hex", 64'(o_hex), 64'(HEX_BEEF));

        // Auto scroll: period, then i_next coincident with terminal count.
        i_mode = 2'd1;
        for (int r = 0; r < 2; r++) begin
            p = o_page; cnt = 0;
            do begin step(1); cnt++; end while (o_page == p && cnt < 30);
        end
        check("auto_period", 64'(cnt), 64'd8);
        p = o_page;
        step(6); i_next = 1; step(1); i_next = 0; step(1);
        check("auto_coincident", 64'(o_page), 64'((int'(p) + 1) % PAGES));

        // Hold: frozen page, no accept.
        i_hold = 1; i_valid = 1; i_data = 32'h1234_5678;
        step(1);
        p = o_page;
        for (int h = 0; h < 19; h++) begin
            step(1);
            check("hold_ready", 64'(o_ready), 64'd0);
            check("hold_page", 64'(o_page), 64'(p));
        end
        i_hold = 0; i_valid = 0;
        step(2);
        check("hold_no_accept", 64'(o_hex), 64'(o_page ? HEX_DEAD : HEX_BEEF));

        // Select page 1, then a new write.
        i_mode = 2'd2; i_page_sel = 1'b1;
        step(2);
        write(32'h1234_5678);
        step(1);
        check("select_page", 64'(o_page), 64'd1);
        check("select_1234", 64'(o_hex), 64'(HEX_1234));

        // Blink.
        i_blink = 1; blanks = 0;
        for (int b = 0; b < 16; b++) begin
            step(1);
            if (o_hex == HEX_OFF) blanks++;
        end
        i_blink = 0;
`ifdef SEVEN_SEG_BLINK_EN
        check("blink_count", 64'(blanks), 64'd8);
`else
        check("blink_count", 64'(blanks), 64'd0);
`endif
        step(2);

        // Asynchronous reset while scrolling.
        i_mode = 2'd1; i_data = 32'hDEAD_BEEF;
        step(12);
        rst_n = 0; #1;
        check("async_hex", 64'(o_hex), 64'(HEX_OFF));
        check("async_page", 64'(o_page), 64'd0);
        step(1);
        rst_n = 1;
        write(32'hDEAD_BEEF);
        step(1);
        check("restart_page", 64'(o_page), 64'd0);
        check("restart_hex", 64'(o_hex), 64'(HEX_BEEF));

        // Randomized traffic, checked by the model.
        cnt = 0;
        for (int t = 0; t < 1500; t++) begin
            if (cnt > 0) cnt--;
            else if ($urandom_range(0, 19) == 0) cnt = $urandom_range(1, 12);
            i_hold = (cnt > 0);
            i_valid = ($urandom_range(0, 15) == 0);
            i_data = $urandom;
            if ($urandom_range(0, 39) == 0) i_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) i_next = ~i_next;
            i_page_sel = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) i_blink = ~i_blink;
            if ($urandom_range(0, 699) == 0) begin
                rst_n = 0; step(1); rst_n = 1;
            end else begin
                step(1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
